// File: rtl/alu_pkg.sv
// Shared opcodes, FSM state encoding and flag bit positions for the pipelined ALU.
package alu_pkg;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_ADC = 4'd2;
    localparam logic [3:0] OP_SBB = 4'd3;
    localparam logic [3:0] OP_AND = 4'd4;
    localparam logic [3:0] OP_OR  = 4'd5;
    localparam logic [3:0] OP_XOR = 4'd6;
    localparam logic [3:0] OP_SHL = 4'd7;
    localparam logic [3:0] OP_SHR = 4'd8;
    localparam logic [3:0] OP_SAR = 4'd9;
    localparam logic [3:0] OP_MUL = 4'd10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_t;

    localparam int FLG_SIGN   = 0;
    localparam int FLG_ZERO   = 1;
    localparam int FLG_CARRY  = 2;
    localparam int FLG_PARITY = 3;
    localparam int FLG_OVF    = 4;
    localparam int NUM_FLAGS  = 5;

endpackage

// File: rtl/alu_mul_seq.sv
// Shift-add unsigned multiplier: WIDTH iterations, the first one done on the start edge,
// so done is high in the cycle before the WIDTH-th edge after start.
module alu_mul_seq #(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               done,
    output logic [2*WIDTH-1:0] prod
);

    localparam int CW = $clog2(WIDTH) + 1;

    logic             busy;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] mcand;

    // prod holds {partial sum, remaining multiplier bits}; each step consumes one multiplier bit
    function automatic logic [2*WIDTH-1:0] step(input logic [2*WIDTH-1:0] p,
                                                input logic [WIDTH-1:0]   m);
        logic [WIDTH:0] s;
        s = {1'b0, p[2*WIDTH-1:WIDTH]} + (p[0] ? {1'b0, m} : '0);
        return {s, p[WIDTH-1:1]};
    endfunction

    assign done = busy && (cnt == CW'(WIDTH));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy  <= 1'b0;
            cnt   <= '0;
            mcand <= '0;
            prod  <= '0;
        end else if (start) begin
            busy  <= 1'b1;
            cnt   <= CW'(1);
            mcand <= a;
            prod  <= step({{WIDTH{1'b0}}, b}, a);
        end else if (done) begin
            busy  <= 1'b0;
        end else if (busy) begin
            prod  <= step(prod, mcand);
            cnt   <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/alu_pipe.sv
// Clocked ALU with registered result/flags behind valid/ready; single-cycle ops plus an
// iterative multiply, one operation in flight.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter bit MUL_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] z,
    output logic             sign,
    output logic             zero,
    output logic             carry,
    output logic             parity,
    output logic             overflow
);

    localparam int AW  = $clog2(WIDTH);
    localparam int MSB = WIDTH - 1;

    typedef struct packed {
        logic [WIDTH-1:0]     z;
        logic [NUM_FLAGS-1:0] flags;
    } res_t;

    state_t             state, state_nxt;
    logic               cf;
    logic               accept, is_mul, mul_done, load;
    logic [2*WIDTH-1:0] prod;
    res_t               alu_res, mul_res, load_res, out_q;

    logic [WIDTH:0]     wide;
    logic [WIDTH-1:0]   zc;
    logic [AW-1:0]      amt;
    logic               c_in, c, v;

    function automatic res_t with_flags(input logic [WIDTH-1:0] zv, input logic cv,
                                        input logic vv);
        res_t r;
        r.z                 = zv;
        r.flags             = '0;
        r.flags[FLG_SIGN]   = zv[MSB];
        r.flags[FLG_ZERO]   = (zv == '0);
        r.flags[FLG_CARRY]  = cv;
        r.flags[FLG_PARITY] = ~^zv;
        r.flags[FLG_OVF]    = vv;
        return r;
    endfunction

    assign in_ready = (state == ST_IDLE) && (!out_valid || out_ready) && !rst;
    assign accept   = in_valid && in_ready;
    assign is_mul   = MUL_EN && (op == OP_MUL);

    alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
        .clk   (clk),
        .rst   (rst),
        .start (accept && is_mul),
        .a     (x),
        .b     (y),
        .done  (mul_done),
        .prod  (prod)
    );

    // Shifts carry the bit shifted out through an extra guard bit in 'wide'
    always_comb begin
        amt  = y[AW-1:0];
        c_in = ((op == OP_ADC) || (op == OP_SBB)) ? cf : 1'b0;
        wide = '0;
        zc   = '0;
        c    = 1'b0;
        v    = 1'b0;
        case (op)
            OP_ADD, OP_ADC: begin
                wide = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, c_in};
                zc   = wide[WIDTH-1:0];
                c    = wide[WIDTH];
                v    = (x[MSB] == y[MSB]) && (zc[MSB] != x[MSB]);
            end
            OP_SUB, OP_SBB: begin
                wide = {1'b0, x} - {1'b0, y} - {{WIDTH{1'b0}}, c_in};
                zc   = wide[WIDTH-1:0];
                c    = wide[WIDTH];
                v    = (x[MSB] != y[MSB]) && (zc[MSB] != x[MSB]);
            end
            OP_AND: zc = x & y;
            OP_OR:  zc = x | y;
            OP_XOR: zc = x ^ y;
            OP_SHL: begin
                wide = {1'b0, x} << amt;
                zc   = wide[WIDTH-1:0];
                c    = wide[WIDTH];
                v    = zc[MSB] ^ c;
            end
            OP_SHR: begin
                wide = {x, 1'b0} >> amt;
                zc   = wide[WIDTH:1];
                c    = wide[0];
            end
            OP_SAR: begin
                wide = $signed({x, 1'b0}) >>> amt;
                zc   = wide[WIDTH:1];
                c    = wide[0];
            end
            default: ;
        endcase
        alu_res = with_flags(zc, c, v);
    end

    assign mul_res  = with_flags(prod[WIDTH-1:0], |prod[2*WIDTH-1:WIDTH],
                                 |prod[2*WIDTH-1:WIDTH]);
    assign load_res = (state == ST_MUL) ? mul_res : alu_res;

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (is_mul) state_nxt = ST_MUL;
                    else        load      = 1'b1;
                end
            end
            ST_MUL: begin
                if (mul_done) begin
                    state_nxt = ST_IDLE;
                    load      = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            out_q     <= '0;
            out_valid <= 1'b0;
            cf        <= 1'b0;
        end else begin
            state <= state_nxt;
            if (load) begin
                out_q     <= load_res;
                out_valid <= 1'b1;
                cf        <= load_res.flags[FLG_CARRY];
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    assign z        = out_q.z;
    assign sign     = out_q.flags[FLG_SIGN];
    assign zero     = out_q.flags[FLG_ZERO];
    assign carry    = out_q.flags[FLG_CARRY];
    assign parity   = out_q.flags[FLG_PARITY];
    assign overflow = out_q.flags[FLG_OVF];

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe: directed vectors push expected results; a monitor pops on each output transfer.
module tb_alu_pipe;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  op = 4'd0;
    logic [15:0] x = 16'd0;
    logic [15:0] y = 16'd0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] z;
    logic        sign, zero, carry, parity, overflow;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string       nm;
        logic [20:0] v;
    } exp_t;
    exp_t sb[$];

    alu_pipe #(.WIDTH(16), .MUL_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op), .x(x), .y(y),
        .out_valid(out_valid), .out_ready(out_ready), .z(z), .sign(sign), .zero(zero),
        .carry(carry), .parity(parity), .overflow(overflow)
    );

    always #5 clk = ~clk;

    function automatic logic [20:0] ev(input logic [15:0] zz, input logic s, input logic zr,
                                       input logic c, input logic p, input logic o);
        return {zz, s, zr, c, p, o};
    endfunction

    function automatic logic [20:0] act();
        return {z, sign, zero, carry, parity, overflow};
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, got, want);
        end
    endtask

    // Each output transfer completes at the next rising edge; sample on the falling edge before it
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_output: got %h want none", act());
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk(e.nm, {11'd0, act()}, {11'd0, e.v});
            end
        end
    end

    task automatic issue(input string nm, input logic [3:0] o, input logic [15:0] a,
                         input logic [15:0] b, input logic [20:0] e, input bit push = 1'b1);
        int n = 0;
        @(negedge clk);
        op = o; x = a; y = b; in_valid = 1'b1;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            total++;
            bad++;
            $display("FAIL %s_accept: in_ready got 0 want 1", nm);
            in_valid = 1'b0;
        end else begin
            if (push) sb.push_back('{nm, e});
            @(posedge clk);
            #1 in_valid = 1'b0;
        end
    endtask

    task automatic mul_check(input string nm, input logic [15:0] a, input logic [15:0] b,
                             input logic [20:0] e);
        int lat = 0;
        bit seen_rdy = 1'b0;
        issue(nm, OP_MUL, a, b, e);
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            if (!out_valid && in_ready) seen_rdy = 1'b1;
        end
        chk({nm, "_latency"}, lat, 16);
        chk({nm, "_in_ready_busy"}, {31'd0, seen_rdy}, 32'd0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset_in_ready", {31'd0, in_ready}, 32'd0);
        chk("reset_result", {11'd0, act()}, 32'd0);
        @(posedge clk);
        #2 rst = 1'b0;

        issue("add_ovf", OP_ADD, 16'h8fff, 16'h8000, ev(16'h0fff, 0, 0, 1, 1, 1));
        chk("add_latency", {31'd0, out_valid}, 32'd1);
        issue("add_wrap", OP_ADD, 16'hfffe, 16'h0002, ev(16'h0000, 0, 1, 1, 1, 0));
        issue("adc_cf", OP_ADC, 16'h0001, 16'h0001, ev(16'h0003, 0, 0, 0, 1, 0));
        issue("xor", OP_XOR, 16'haaaa, 16'h5555, ev(16'hffff, 1, 0, 0, 1, 0));
        issue("sub_borrow", OP_SUB, 16'h0000, 16'h0001, ev(16'hffff, 1, 0, 1, 1, 0));
        issue("sbb_borrow", OP_SBB, 16'h0005, 16'h0002, ev(16'h0002, 0, 0, 0, 0, 0));
        issue("and", OP_AND, 16'hffff, 16'h0f0f, ev(16'h0f0f, 0, 0, 0, 1, 0));
        issue("or_zero", OP_OR, 16'h0000, 16'h0000, ev(16'h0000, 0, 1, 0, 1, 0));
        issue("sar", OP_SAR, 16'h8001, 16'h0001, ev(16'hc000, 1, 0, 1, 1, 0));
        issue("shl_ovf", OP_SHL, 16'h4000, 16'h0001, ev(16'h8000, 1, 0, 0, 0, 1));
        issue("shr_zero_amt", OP_SHR, 16'h1234, 16'h0000, ev(16'h1234, 0, 0, 0, 0, 0));
        issue("shr_amt_mask", OP_SHR, 16'h0003, 16'h0011, ev(16'h0001, 0, 0, 1, 0, 0));
        issue("add_set_cf", OP_ADD, 16'hffff, 16'h0001, ev(16'h0000, 0, 1, 1, 1, 0));
        issue("illegal", 4'hf, 16'h1234, 16'h5678, ev(16'h0000, 0, 1, 0, 1, 0));
        issue("adc_after_illegal", OP_ADC, 16'h0001, 16'h0001, ev(16'h0002, 0, 0, 0, 0, 0));

        mul_check("mul_hi", 16'h0100, 16'h0100, ev(16'h0000, 0, 1, 1, 1, 1));
        mul_check("mul_lo", 16'h0003, 16'h0005, ev(16'h000f, 0, 0, 0, 1, 0));

        // Stall: let the last result drain, then hold out_ready low on a fresh one
        @(posedge clk);
        #1 out_ready = 1'b0;
        issue("stall_add", OP_ADD, 16'h0001, 16'h0001, ev(16'h0002, 0, 0, 0, 0, 0));
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("stall_hold", {11'd0, act()}, {11'd0, ev(16'h0002, 0, 0, 0, 0, 0)});
            chk("stall_valid", {31'd0, out_valid}, 32'd1);
            chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1 chk("stall_release", {31'd0, out_valid}, 32'd0);

        // Abort a multiply with reset; no result may appear
        issue("mul_abort", OP_MUL, 16'h0003, 16'h0005, '0, 1'b0);
        repeat (5) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
        chk("abort_in_ready", {31'd0, in_ready}, 32'd0);
        chk("abort_result", {11'd0, act()}, 32'd0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        #1 chk("post_reset_in_ready", {31'd0, in_ready}, 32'd1);
        issue("adc_after_reset", OP_ADC, 16'h0002, 16'h0003, ev(16'h0005, 0, 0, 0, 1, 0));

        for (int i = 0; i < 100 && (sb.size() != 0 || out_valid); i++) @(posedge clk);
        #1;
        chk("scoreboard_drained", sb.size(), 32'd0);
        chk("final_out_valid", {31'd0, out_valid}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
